// File: rtl/apb_ms_pkg.sv
// rtl/apb_ms_pkg.sv - shared FSM state and request payload types for apb_master_ms
package apb_ms_pkg;

    // Widest configuration the queued payload can carry; narrower builds zero-fill the top bits.
    localparam int MAX_AW = 64;
    localparam int MAX_DW = 128;
    localparam int MAX_SW = MAX_DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_ms_state_t;

    typedef struct packed {
        logic [MAX_AW-1:0] addr;
        logic [MAX_DW-1:0] wdata;
        logic              write;
        logic [MAX_SW-1:0] strb;
        logic [2:0]        prot;
    } apb_ms_req_t;

endpackage

// File: rtl/apb_master_ms_if.sv
// rtl/apb_master_ms_if.sv - request/response and APB bus bundle with master/slave modports
interface apb_master_ms_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
) ();

    logic                             req_valid;
    logic                             req_ready;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [DATA_WIDTH-1:0]            req_wdata;
    logic                             req_write;
    logic [DATA_WIDTH/8-1:0]          req_strb;
    logic [2:0]                       req_prot;

    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [DATA_WIDTH-1:0]            rsp_rdata;
    logic                             rsp_error;

    logic [ADDR_WIDTH-1:0]            paddr;
    logic [DATA_WIDTH-1:0]            pwdata;
    logic                             pwrite;
    logic                             penable;
    logic [DATA_WIDTH/8-1:0]          pstrb;
    logic [2:0]                       pprot;
    logic [NUM_SLAVES-1:0]            psel;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata;
    logic [NUM_SLAVES-1:0]            pready;
    logic [NUM_SLAVES-1:0]            pslverr;

    modport master (
        input  req_valid, req_addr, req_wdata, req_write, req_strb, req_prot,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready,
        output paddr, pwdata, pwrite, penable, pstrb, pprot, psel,
        input  prdata, pready, pslverr
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_write, req_strb, req_prot,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready,
        input  paddr, pwdata, pwrite, penable, pstrb, pprot, psel,
        output prdata, pready, pslverr
    );

endinterface

// File: rtl/apb_ms_req_fifo.sv
// rtl/apb_ms_req_fifo.sv - request queue with extra-bit pointers for full/empty
module apb_ms_req_fifo
    import apb_ms_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  apb_ms_req_t din,
    input  logic        pop,
    output apb_ms_req_t dout,
    output logic        full,
    output logic        empty
);

    localparam int PW = $clog2(FIFO_DEPTH);

    apb_ms_req_t mem_q [FIFO_DEPTH];
    apb_ms_req_t mem_d [FIFO_DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign dout    = mem_q[rd_ptr_q[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers and payload write; the index bits wrap naturally modulo the depth
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; clearing them is what empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/apb_master_ms.sv
// rtl/apb_master_ms.sv - queued APB master, multi-slave; APB_MASTER_MS_TIMEOUT_EN adds an ACCESS timeout
module apb_master_ms
    import apb_ms_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            pclk,
    input  logic            preset,
    apb_master_ms_if.master bus
);

    localparam int SW = $clog2(NUM_SLAVES);
    localparam int BW = DATA_WIDTH / 8;

    apb_ms_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [BW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_error_q, rsp_error_d;

    apb_ms_req_t           fifo_din, fifo_dout;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SW-1:0]         sel_idx;
    logic                  sel_ready, sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  unused_head;

`ifdef APB_MASTER_MS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Widen the incoming request into the shared payload format
    always_comb begin
        fifo_din.addr  = MAX_AW'(bus.req_addr);
        fifo_din.wdata = MAX_DW'(bus.req_wdata);
        fifo_din.write = bus.req_write;
        fifo_din.strb  = MAX_SW'(bus.req_strb);
        fifo_din.prot  = bus.req_prot;
    end

    assign fifo_push     = bus.req_valid && !fifo_full;
    assign bus.req_ready = !fifo_full;
    assign unused_head   = ^fifo_dout;

    apb_ms_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_req_fifo (
        .clk   (pclk),
        .rst   (preset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Only the addressed slave's handshake, error and data are looked at
    assign sel_idx   = paddr_q[ADDR_WIDTH-1 -: SW];
    assign sel_ready = bus.pready[sel_idx];
    assign sel_err   = bus.pslverr[sel_idx];
    assign sel_rdata = bus.prdata[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Transfer sequencing; a pop in IDLE or RESP loads the next request's bus fields
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        fifo_pop    = 1'b0;
`ifdef APB_MASTER_MS_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
`ifdef APB_MASTER_MS_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                    rsp_error_d = sel_err;
                    state_d     = ST_RESP;
                end
`ifdef APB_MASTER_MS_TIMEOUT_EN
                else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fifo_pop) begin
            paddr_d  = ADDR_WIDTH'(fifo_dout.addr);
            pwdata_d = DATA_WIDTH'(fifo_dout.wdata);
            pwrite_d = fifo_dout.write;
            pstrb_d  = fifo_dout.write ? BW'(fifo_dout.strb) : '0;
            pprot_d  = fifo_dout.prot;
        end
    end

    // State and registered bus/response fields
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
        end
    end

`ifdef APB_MASTER_MS_TIMEOUT_EN
    // ACCESS-cycle counter, only meaningful while waiting in ACCESS
    always_ff @(posedge pclk) begin
        if (preset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    // One-hot select for the addressed slave during SETUP and ACCESS
    always_comb begin
        bus.psel = '0;
        if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
            bus.psel[sel_idx] = 1'b1;
        end
    end

    assign bus.penable   = (state_q == ST_ACCESS);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.pprot     = pprot_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule

// File: tb/tb_apb_master_ms.sv
// tb/tb_apb_master_ms.sv - directed self-checking bench for apb_master_ms
module tb_apb_master_ms;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int FD = 4;
    localparam int TC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    apb_master_ms_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    apb_master_ms #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TC)
    ) dut (
        .pclk   (clk),
        .preset (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic v, input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] s, input logic [2:0] p);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_write = w;
        bus.req_strb  = s;
        bus.req_prot  = p;
    endtask

    task automatic test_reset();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        bus.rsp_ready = 1'b0;
        bus.pready    = 4'b1111;
        bus.pslverr   = 4'b0000;
        bus.prdata    = '0;
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.psel !== 4'b0000) begin errors++; $display("FAIL rst_psel: got %h want 0", bus.psel); end
        checks++; if (bus.penable !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b want 0", bus.penable); end
        checks++; if (bus.pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwrite: got %b want 0", bus.pwrite); end
        checks++; if (bus.paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr: got %h want 0", bus.paddr); end
        checks++; if (bus.pwdata !== 32'h0) begin errors++; $display("FAIL rst_pwdata: got %h want 0", bus.pwdata); end
        checks++; if (bus.pstrb !== 4'h0) begin errors++; $display("FAIL rst_pstrb: got %h want 0", bus.pstrb); end
        checks++; if (bus.pprot !== 3'h0) begin errors++; $display("FAIL rst_pprot: got %h want 0", bus.pprot); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_error !== 1'b0) begin errors++; $display("FAIL rst_rsp_error: got %b want 0", bus.rsp_error); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        bus.pready = 4'b1111;
        drive_req(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 3'b010);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        checks++; if (bus.psel !== 4'b0000) begin errors++; $display("FAIL wr_n_psel: got %h want 0", bus.psel); end
        tick();
        checks++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b0) begin errors++; $display("FAIL wr_setup: got psel=%h pen=%b want psel=2 pen=0", bus.psel, bus.penable); end
        checks++; if (bus.paddr !== 32'h4000_0010 || bus.pwdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_addr_data: got %h/%h want 40000010/deadbeef", bus.paddr, bus.pwdata); end
        checks++; if (bus.pwrite !== 1'b1 || bus.pstrb !== 4'hF || bus.pprot !== 3'b010) begin errors++; $display("FAIL wr_ctrl: got w=%b strb=%h prot=%h want 1/f/2", bus.pwrite, bus.pstrb, bus.pprot); end
        tick();
        checks++; if (bus.psel !== 4'b0010 || bus.penable !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_access: got psel=%h pen=%b rv=%b want 2/1/0", bus.psel, bus.penable, bus.rsp_valid); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_resp: got rv=%b err=%b rd=%h want 1/0/0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
        checks++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin errors++; $display("FAIL wr_resp_bus: got psel=%h pen=%b want 0/0", bus.psel, bus.penable); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_done: got rv=%b want 0", bus.rsp_valid); end
    endtask

    task automatic test_read_wait();
        bus.pready  = 4'b0111;
        bus.pslverr = 4'b0111;
        bus.prdata  = {32'h1234_5678, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        drive_req(1'b1, 32'hC000_0000, 32'hFFFF_FFFF, 1'b0, 4'hF, 3'b000);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        tick();
        checks++; if (bus.psel !== 4'b1000 || bus.pstrb !== 4'h0 || bus.pwrite !== 1'b0) begin errors++; $display("FAIL rd_setup: got psel=%h strb=%h w=%b want 8/0/0", bus.psel, bus.pstrb, bus.pwrite); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.penable !== 1'b1 || bus.pstrb !== 4'h0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait%0d: got pen=%b strb=%h rv=%b want 1/0/0", i, bus.penable, bus.pstrb, bus.rsp_valid); end
            tick();
        end
        bus.pready[3] = 1'b1;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_error !== 1'b0) begin errors++; $display("FAIL rd_resp: got rv=%b rd=%h err=%b want 1/12345678/0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_error); end
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_hold: got rv=%b rd=%h want 1/12345678", bus.rsp_valid, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.pslverr   = 4'b0000;
        bus.pready    = 4'b1111;
    endtask

    task automatic test_slverr();
        bus.pready  = 4'b1111;
        bus.pslverr = 4'b0100;
        bus.prdata  = {32'h0, 32'h55AA_55AA, 32'h0, 32'h0};
        drive_req(1'b1, 32'h8000_0004, 32'h0, 1'b0, 4'hF, 3'b001);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        tick();
        checks++; if (bus.psel !== 4'b0100) begin errors++; $display("FAIL err_psel: got %h want 4", bus.psel); end
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h55AA_55AA) begin errors++; $display("FAIL err_resp: got rv=%b err=%b rd=%h want 1/1/55aa55aa", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        bus.pslverr   = 4'b0000;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_addr [5];
        logic [31:0] exp_data [5];
        logic        exp_wr   [5];
        int          waited;
        logic        bad;
        exp_addr = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300, 32'hC000_0400, 32'h4000_0500};
        exp_data = '{32'h0F0F_0F0F, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h0000_0000};
        exp_wr   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.pready    = 4'b1111;
        bus.prdata    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0F0F_0F0F};
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, exp_addr[0], 32'hA0A0_0000, exp_wr[0], 4'hF, 3'h0);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        tick();
        tick();
        tick();
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_stall: got rv=%b want 1", bus.rsp_valid); end
        for (int i = 1; i < 5; i++) begin
            checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.req_ready); end
            drive_req(1'b1, exp_addr[i], 32'hA0A0_0000 + i, exp_wr[i], 4'hF, 3'h0);
            tick();
        end
        checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: got req_ready=%b want 0", bus.req_ready); end
        drive_req(1'b1, 32'h8000_0600, 32'hBAD0_BAD0, 1'b0, 4'hF, 3'h0);
        tick();
        tick();
        checks++; if (bus.req_ready !== 1'b0 || bus.psel !== 4'b0000) begin errors++; $display("FAIL b2b_stalled: got req_ready=%b psel=%h want 0/0", bus.req_ready, bus.psel); end
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            waited = 0;
            while (bus.rsp_valid !== 1'b1 && waited < 20) begin
                tick();
                waited++;
            end
            checks++;
            if (bus.rsp_valid !== 1'b1) begin
                errors++; $display("FAIL b2b_timeout%0d: got no rsp_valid want rsp_valid within 20 cycles", k);
            end else if (bus.paddr !== exp_addr[k] || bus.rsp_rdata !== exp_data[k] || bus.rsp_error !== 1'b0) begin
                errors++; $display("FAIL b2b_rsp%0d: got addr=%h rd=%h err=%b want %h/%h/0", k, bus.paddr, bus.rsp_rdata, bus.rsp_error, exp_addr[k], exp_data[k]);
            end
            tick();
        end
        bad = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 4'b0000) bad = 1'b1;
            tick();
        end
        checks++; if (bad !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_drained: got extra=%b req_ready=%b want 0/1", bad, bus.req_ready); end
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic bad;
        bus.pready    = 4'b0000;
        bus.prdata    = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0040, 32'h0, 1'b0, 4'hF, 3'h0);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        tick();
        tick();
        bad = 1'b0;
`ifdef APB_MASTER_MS_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.penable !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL tmo_early: got early exit from ACCESS want 16 ACCESS cycles"); end
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL tmo_resp: got rv=%b err=%b rd=%h want 1/1/0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
        checks++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0) begin errors++; $display("FAIL tmo_bus: got psel=%h pen=%b want 0/0", bus.psel, bus.penable); end
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.penable !== 1'b1 || bus.psel !== 4'b0001 || bus.rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL notmo_wait: got left ACCESS want ACCESS after 100 cycles"); end
        bus.pready = 4'b1111;
        tick();
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL notmo_resp: got rv=%b err=%b rd=%h want 1/0/ffffffff", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
`endif
        bus.pready    = 4'b1111;
        bus.rsp_ready = 1'b1;
        tick();
        tick();
        bus.rsp_ready = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.psel !== 4'b0000) begin errors++; $display("FAIL tmo_recover: got rv=%b psel=%h want 0/0", bus.rsp_valid, bus.psel); end
    endtask

    task automatic test_reset_mid();
        logic bad;
        bus.pready    = 4'b0000;
        bus.rsp_ready = 1'b0;
        drive_req(1'b1, 32'h0000_0010, 32'h1111_0000, 1'b1, 4'hF, 3'h0);
        tick();
        drive_req(1'b1, 32'h4000_0020, 32'h2222_0000, 1'b1, 4'hF, 3'h0);
        tick();
        drive_req(1'b1, 32'h8000_0030, 32'h3333_0000, 1'b0, 4'hF, 3'h0);
        tick();
        drive_req(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 3'h0);
        checks++; if (bus.penable !== 1'b1 || bus.psel !== 4'b0001) begin errors++; $display("FAIL mid_access: got pen=%b psel=%h want 1/1", bus.penable, bus.psel); end
        rst = 1'b1;
        tick();
        checks++; if (bus.psel !== 4'b0000 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst: got psel=%h pen=%b rv=%b want 0/0/0", bus.psel, bus.penable, bus.rsp_valid); end
        checks++; if (bus.req_ready !== 1'b1 || bus.paddr !== 32'h0) begin errors++; $display("FAIL mid_rst_state: got req_ready=%b paddr=%h want 1/0", bus.req_ready, bus.paddr); end
        rst = 1'b0;
        bus.pready    = 4'b1111;
        bus.rsp_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid !== 1'b0 || bus.psel !== 4'b0000) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_discard: got activity after reset want none"); end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1);
    end

endmodule
